sap1_controller_sequencer: RTL



---
 rtl/sap1_controller_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller/sequencer.
//
// Drives the 12-bit control word that strobes every register in the SAP-1 datapath. A one-hot
// six-state ring (T1..T6) advances on the falling edge of CLK, so CON is settled well before the
// rising edge on which the datapath registers load. CON is a pure decode of the ring state and
// the opcode nibble from the instruction register.
//
// Ports:
//   CLK      system clock; the ring advances on its falling edge
//   CLR      asynchronous active-high reset (ring to T1, halt cleared)
//   opcode   upper nibble of the instruction register; must be stable during T4..T6
//   CON      control word:
//            [11]Cp [10]Ep [9]L_M_bar [8]CE_bar [7]L_I_bar [6]E_I_bar
//            [5]L_A_bar [4]E_A [3]Su [2]E_U [1]L_B_bar [0]L_O_bar
//   T        one-hot ring state, T[0]=T1 .. T[5]=T6
//   HLT_bar  low while halted; gates the external clock
//
// Build option:
//   VARIABLE_MACHINE_CYCLE_EN  when defined, the ring returns to T1 right after the last
//                              active execute state of each instruction instead of always
//                              running through T6.

module sap1_controller_sequencer #(
    parameter logic [3:0] LDA_OP = 4'h0,
    parameter logic [3:0] ADD_OP = 4'h1,
    parameter logic [3:0] SUB_OP = 4'h2,
    parameter logic [3:0] OUT_OP = 4'hE,
    parameter logic [3:0] HLT_OP = 4'hF
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [3:0]  opcode,
    output logic [11:0] CON,
    output logic [5:0]  T,
    output logic        HLT_bar
);

    typedef enum logic [5:0] {
        StT1 = 6'b000001,
        StT2 = 6'b000010,
        StT3 = 6'b000100,
        StT4 = 6'b001000,
        StT5 = 6'b010000,
        StT6 = 6'b100000
    } state_e;

    localparam logic [11:0] ConIdle   = 12'h3E3;
    localparam logic [11:0] ConFetch1 = 12'h5E3;  // Ep, L_M_bar
    localparam logic [11:0] ConFetch2 = 12'hBE3;  // Cp
    localparam logic [11:0] ConFetch3 = 12'h263;  // CE_bar, L_I_bar
    localparam logic [11:0] ConAddrIr = 12'h1A3;  // E_I_bar, L_M_bar
    localparam logic [11:0] ConLdaT5  = 12'h2C3;  // CE_bar, L_A_bar
    localparam logic [11:0] ConLoadB  = 12'h2E1;  // CE_bar, L_B_bar
    localparam logic [11:0] ConAddT6  = 12'h3C7;  // E_U, L_A_bar
    localparam logic [11:0] ConSubT6  = 12'h3CF;  // E_U, L_A_bar, Su
    localparam logic [11:0] ConOutT4  = 12'h3F2;  // E_A, L_O_bar

    state_e state_q, state_d;
    logic   halted_q, halted_d;

    logic is_lda, is_add, is_sub, is_out, is_hlt;
    logic halt_now;
    logic end_at_t4, end_at_t5;

    always_comb begin
        is_lda = (opcode == LDA_OP);
        is_add = (opcode == ADD_OP);
        is_sub = (opcode == SUB_OP);
        is_out = (opcode == OUT_OP);
        is_hlt = (opcode == HLT_OP);
    end

    // Halt is recognised combinationally in T4 so HLT_bar can stop the external clock
    // before the next edge; the flag then latches on that falling edge.
    assign halt_now = (state_q == StT4) && is_hlt && !halted_q;

`ifdef VARIABLE_MACHINE_CYCLE_EN
    // OUT and NOP finish in T4, LDA in T5; ADD/SUB use the full ring. HLT never leaves T4.
    assign end_at_t4 = !(is_lda || is_add || is_sub || is_hlt);
    assign end_at_t5 = is_lda;
`else
    assign end_at_t4 = 1'b0;
    assign end_at_t5 = 1'b0;
`endif

    always_ff @(negedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q  <= StT1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (halted_q) begin
            state_d = state_q;
        end else if (halt_now) begin
            halted_d = 1'b1;
        end else begin
            unique case (state_q)
                StT1:    state_d = StT2;
                StT2:    state_d = StT3;
                StT3:    state_d = StT4;
                StT4:    state_d = end_at_t4 ? StT1 : StT5;
                StT5:    state_d = end_at_t5 ? StT1 : StT6;
                StT6:    state_d = StT1;
                default: state_d = StT1;
            endcase
        end
    end

    always_comb begin
        CON = ConIdle;
        if (!halted_q) begin
            unique case (state_q)
                StT1: CON = ConFetch1;
                StT2: CON = ConFetch2;
                StT3: CON = ConFetch3;
                StT4: begin
                    if (is_lda || is_add || is_sub) begin
                        CON = ConAddrIr;
                    end else if (is_out) begin
                        CON = ConOutT4;
                    end
                end
                StT5: begin
                    if (is_lda) begin
                        CON = ConLdaT5;
                    end else if (is_add || is_sub) begin
                        CON = ConLoadB;
                    end
                end
                StT6: begin
                    if (is_add) begin
                        CON = ConAddT6;
                    end else if (is_sub) begin
                        CON = ConSubT6;
                    end
                end
                default: CON = ConIdle;
            endcase
        end
    end

    assign T       = state_q;
    assign HLT_bar = !(halted_q || halt_now);

endmodule
